booth_mul_arbiter: RTL

Shares one 5-bit serial Booth multiplier (`booth5b` instance) between two requesters. Each requester presents a pair of signed 5-bit operands. The block grants the multiplier round-robin, sequences the multiplier's serial load / compute / unload protocol, and returns the signed 10-bit product with a one-cycle acknowledge. It sits between client logic and the multiplier's `inBus`/`start`/`done`/`outBus` pins.

---
 rtl/booth_arb_pkg.sv | 20 ++
 rtl/booth_mul_arbiter_rr_arb2.sv | 30 +++
 rtl/booth_mul_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg: shared types and constants for booth_mul_arbiter.
//   state_e     : sequencing FSM states
//   OPW / RESW  : operand width (5) and product width (10)
//   TIMEOUT_DEF : default WAIT-cycle limit for the optional timeout
package booth_arb_pkg;

  localparam int OPW         = 5;
  localparam int RESW        = 10;
  localparam int TIMEOUT_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_X,
    S_SEND_Y,
    S_WAIT,
    S_READ_LO,
    S_RESP
  } state_e;

endpackage

// File: rtl/booth_mul_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   clk, rst     : clock, async active-low reset
//   req_i[1:0]   : request vector
//   upd_i        : load the last-served pointer with upd_idx_i
//   upd_idx_i    : index that was just served
//   gnt_vld_o    : some request is present
//   gnt_idx_o    : granted index (valid with gnt_vld_o)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  // Pointer resets to 1 so requester 0 wins the first tie.
  logic last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       last_q <= 1'b1;
    else if (upd_i) last_q <= upd_idx_i;
  end

  assign gnt_vld_o = |req_i;
  // Tie: serve whoever was not served last; otherwise the lone requester.
  assign gnt_idx_o = (&req_i) ? ~last_q : req_i[1];

endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: shares one serial 5-bit Booth multiplier between two
// requesters, sequencing its load X / load Y / wait / read hi / read lo
// protocol and returning a signed 10-bit product with a one-cycle ack.
//   clk, rst              : clock, async active-low reset (also resets multiplier)
//   req0/1, a0/b0, a1/b1  : requests and signed operands (stable until ack)
//   ack0/1, res0/1, err0/1: completion pulse, held product, abort flag
//   busy                  : FSM not idle
//   mul_start, mul_in     : multiplier start / inBus
//   mul_done, mul_out     : multiplier done / outBus
// Optional feature: define BOOTH_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles (ack with err=1, res=0). Without it err0/err1 are 0.
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            req1,
  input  logic [OPW-1:0]  a0,
  input  logic [OPW-1:0]  b0,
  input  logic [OPW-1:0]  a1,
  input  logic [OPW-1:0]  b1,
  output logic            ack0,
  output logic            ack1,
  output logic [RESW-1:0] res0,
  output logic [RESW-1:0] res1,
  output logic            err0,
  output logic            err1,
  output logic            busy,
  output logic            mul_start,
  output logic [OPW-1:0]  mul_in,
  input  logic            mul_done,
  input  logic [OPW-1:0]  mul_out
);

  state_e          state_q, state_d;
  logic            g_q;
  logic [OPW-1:0]  hi_q;
  logic [RESW-1:0] res0_q, res1_q;
  logic            gnt_vld, gnt_idx, to_hit, resp;

  assign resp = (state_q == S_RESP);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     ({req1, req0}),
    .upd_i     (resp),
    .upd_idx_i (g_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

`ifdef BOOTH_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_SEND_Y)    cnt_q <= '0;          // cleared on WAIT entry
      else if (state_q == S_WAIT) cnt_q <= cnt_q + 8'd1;
      if (state_q == S_SEND_X)    err_q <= 1'b0;
      else if (to_hit && !mul_done) err_q <= 1'b1;
    end
  end

  // Last permitted WAIT cycle; a done in this same cycle still wins.
  assign to_hit = (state_q == S_WAIT) && (cnt_q == 8'(TIMEOUT - 1));
  assign err0   = resp && !g_q && err_q;
  assign err1   = resp &&  g_q && err_q;
`else
  // TIMEOUT only matters when the counter is built.
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign to_hit = 1'b0;
  assign err0   = 1'b0;
  assign err1   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (gnt_vld) state_d = S_SEND_X;
      S_SEND_X:  state_d = S_SEND_Y;
      S_SEND_Y:  state_d = S_WAIT;
      S_WAIT: begin
        if (mul_done)    state_d = S_READ_LO;
        else if (to_hit) state_d = S_RESP;
      end
      S_READ_LO: state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // The result register is loaded on the edge into RESP so the product is
  // already visible in the ack cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      g_q     <= 1'b0;
      hi_q    <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && gnt_vld) g_q <= gnt_idx;
      if (state_q == S_WAIT && mul_done) hi_q <= mul_out;
      if (state_q == S_READ_LO) begin
        if (g_q) res1_q <= {hi_q, mul_out};
        else     res0_q <= {hi_q, mul_out};
      end else if (to_hit && !mul_done) begin
        if (g_q) res1_q <= '0;
        else     res0_q <= '0;
      end
    end
  end

  always_comb begin
    mul_in = '0;
    if (state_q == S_SEND_X)      mul_in = g_q ? a1 : a0;
    else if (state_q == S_SEND_Y) mul_in = g_q ? b1 : b0;
  end

  assign mul_start = (state_q == S_SEND_X);
  assign busy      = (state_q != S_IDLE);
  assign ack0      = resp && !g_q;
  assign ack1      = resp &&  g_q;
  assign res0      = res0_q;
  assign res1      = res1_q;

endmodule
